dma_acc_source: RTL and testbench

Transmit-side streamer that drives the accelerator input stream (`acc_data_*`) from cache lines returned by the DMA read engine. It buffers incoming 512-bit lines in a small FIFO and paces them to the accelerator under the 2-cycle ready tolerance. From a programmed transfer length it generates the per-beat byte count and end-of-packet flag. It sits between the DMA read engine and any accelerator core, on the source side of the accelerator data interface.

---
 rtl/dma_acc_source_if.sv | 24 ++
 rtl/dma_acc_source.sv | 111 +++++++++++
 tb/tb_dma_acc_source.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_acc_source_if.sv
// Bus bundle for dma_acc_source: read-engine line input and accelerator beat output.
// The streamer uses the slave view; the surrounding environment uses the master view.
interface dma_acc_source_if #(
  parameter int bus_width = 512
) ();
  logic                 line_val_i;
  logic [bus_width-1:0] line_dat_i;
  logic                 line_ready_o;
  logic                 acc_data_ready_i;
  logic                 acc_data_val_o;
  logic [bus_width-1:0] acc_data_dat_o;
  logic                 acc_data_eop_o;
  logic [0:6]           acc_data_byte_o;

  modport slave (
    input  line_val_i, line_dat_i, acc_data_ready_i,
    output line_ready_o, acc_data_val_o, acc_data_dat_o, acc_data_eop_o, acc_data_byte_o
  );

  modport master (
    output line_val_i, line_dat_i, acc_data_ready_i,
    input  line_ready_o, acc_data_val_o, acc_data_dat_o, acc_data_eop_o, acc_data_byte_o
  );
endinterface

// File: rtl/dma_acc_source.sv
// Streams DMA cache lines through a small FIFO to the accelerator input, generating
// per-beat byte counts and end-of-packet from a programmed transfer length.
module dma_acc_source #(
  parameter int bus_width  = 512,
  parameter int fifo_depth = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [31:0]       len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  dma_acc_source_if.slave   bus
);
  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW:0] READY_LIM = (AW+1)'(fifo_depth - 3);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(fifo_depth);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t r_state, w_state_next;

  logic [bus_width-1:0] r_mem [fifo_depth];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [31:0]          r_rem;
  logic [26:0]          r_lines_left;
  logic                 r_ready_q, r_line_ready, r_val, r_eop, r_done, r_err;
  logic [6:0]           r_byte;
  logic [bus_width-1:0] r_dat;

  logic       w_full, w_push, w_drop, w_pop, w_start_ok, w_eop_seen;
  logic [6:0] w_beat_bytes;

  // full is judged before any same-cycle pop, so a push into a full FIFO is always dropped
  assign w_full       = (r_count == FULL_CNT);
  assign w_push       = bus.line_val_i && (r_state == S_STREAM) && (r_lines_left != '0) && !w_full;
  assign w_drop       = bus.line_val_i && !w_push;
  assign w_pop        = (r_state == S_STREAM) && (r_count != '0) && r_ready_q;
  assign w_start_ok   = (r_state == S_IDLE) && start_i;
  assign w_eop_seen   = (r_state == S_STREAM) && r_val && r_eop;
  assign w_beat_bytes = (r_rem >= 32'd64) ? 7'd64 : r_rem[6:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i && (len_i != '0)) w_state_next = S_STREAM;
      S_STREAM: if (w_eop_seen) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rem        <= '0;
      r_lines_left <= '0;
      r_ready_q    <= 1'b0;
      r_line_ready <= 1'b0;
      r_val        <= 1'b0;
      r_eop        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_byte       <= '0;
      r_dat        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ready_q    <= bus.acc_data_ready_i;
      r_line_ready <= (r_count <= READY_LIM);
      r_done       <= (w_start_ok && (len_i == '0)) || w_eop_seen;
      if (w_drop)          r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;

      if (w_start_ok) begin
        r_rem        <= len_i;
        r_lines_left <= {1'b0, len_i[31:6]} + 27'(|len_i[5:0]);
      end else begin
        if (w_push) r_lines_left <= r_lines_left - 27'd1;
        if (w_pop)  r_rem        <= r_rem - 32'(w_beat_bytes);
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

      // data/eop/byte hold their last value while no beat issues
      r_val <= w_pop;
      if (w_pop) begin
        r_dat  <= r_mem[r_rd_ptr];
        r_byte <= w_beat_bytes;
        r_eop  <= (r_rem <= 32'd64);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.line_dat_i;
  end

  assign busy_o               = (r_state == S_STREAM);
  assign done_o               = r_done;
  assign err_o                = r_err;
  assign bus.line_ready_o     = r_line_ready;
  assign bus.acc_data_val_o   = r_val;
  assign bus.acc_data_dat_o   = r_dat;
  assign bus.acc_data_eop_o   = r_eop;
  assign bus.acc_data_byte_o  = r_byte;
endmodule

// File: tb/tb_dma_acc_source.sv
// Directed and randomized bench for dma_acc_source; beats are checked against a
// length-driven reference of expected data, byte counts, eop and ready pacing.
`timescale 1ns/1ps
module tb_dma_acc_source;
  localparam int BW    = 512;
  localparam int DEPTH = 8;
  localparam int MAXC  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic        busy_o, done_o, err_o;

  dma_acc_source_if #(.bus_width(BW)) bus ();

  dma_acc_source #(.bus_width(BW), .fifo_depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [BW-1:0] dat;
    logic [6:0]    nb;
    logic          eop;
  } beat_t;

  beat_t         obs_q[$];
  logic [BW-1:0] exp_q[$];
  int  cyc = 0;
  bit  mon_val[MAXC], mon_rdy[MAXC], mon_done[MAXC], mon_busy[MAXC];
  int  done_count = 0, last_done = 0;
  int  checks = 0, errors = 0;

  // monitor: cycle n's outputs are sampled on its falling edge
  always @(negedge clk) begin
    logic [6:0] b;
    cyc = cyc + 1;
    if (cyc < MAXC) begin
      mon_val[cyc]  = bus.acc_data_val_o;
      mon_rdy[cyc]  = bus.acc_data_ready_i;
      mon_done[cyc] = done_o;
      mon_busy[cyc] = busy_o;
    end
    if (bus.acc_data_val_o === 1'b1) begin
      b = bus.acc_data_byte_o;
      obs_q.push_back('{cyc, bus.acc_data_dat_o, b, bus.acc_data_eop_o});
      $display("beat cyc=%0d bytes=%0d eop=%0d dat[31:0]=%h", cyc, b, bus.acc_data_eop_o, bus.acc_data_dat_o[31:0]);
    end
    if (done_o === 1'b1) begin
      done_count = done_count + 1;
      last_done  = cyc;
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int now();
    return cyc + 1;
  endfunction

  function automatic logic [BW-1:0] rnd_line();
    logic [BW-1:0] v;
    for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [6:0] exp_nb(input int len, input int i);
    int r;
    r = len - 64*i;
    return (r >= 64) ? 7'd64 : 7'(r);
  endfunction

  task automatic start_xfer(input int len);
    start_i = 1'b1;
    len_i   = len;
    step();
    start_i = 1'b0;
    $display("start len=%0d", len);
  endtask

  task automatic push(input logic [BW-1:0] line);
    bus.line_val_i = 1'b1;
    bus.line_dat_i = line;
    step();
    bus.line_val_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, input int d0);
    for (int i = 0; i < bound && done_count == d0; i++) step();
    step();
    chk({tag, "_done"}, done_count - d0, 1);
  endtask

  task automatic verify(input string tag, input int len, input int base);
    int nbeats;
    nbeats = (len + 63) / 64;
    chk({tag, "_nbeats"}, obs_q.size() - base, nbeats);
    for (int i = 0; i < nbeats && base + i < obs_q.size(); i++) begin
      chk({tag, "_data"}, obs_q[base+i].dat, exp_q[i]);
      chk({tag, "_bytes"}, obs_q[base+i].nb, exp_nb(len, i));
      chk({tag, "_eop"}, obs_q[base+i].eop, (i == nbeats - 1));
      chk({tag, "_pace"}, mon_rdy[obs_q[base+i].cyc - 2], 1);
    end
  endtask

  initial begin
    int base, d0, p, s, k, pushed, len, nl, dr, busy_sum;
    logic [BW-1:0] line;

    bus.line_val_i       = 1'b0;
    bus.line_dat_i       = '0;
    bus.acc_data_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_val",   bus.acc_data_val_o, 0);
    chk("rst_eop",   bus.acc_data_eop_o, 0);
    chk("rst_byte",  bus.acc_data_byte_o, 0);
    chk("rst_dat",   bus.acc_data_dat_o, 0);
    chk("rst_lrdy",  bus.line_ready_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_err",   err_o, 0);
    reset = 1'b0;
    bus.acc_data_ready_i = 1'b1;
    step(); step();
    chk("lrdy_after_rst", bus.line_ready_o, 1);

    // 256 bytes, 4 back-to-back lines
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(256);
    chk("t1_busy", busy_o, 1);
    p = now();
    for (int i = 0; i < 4; i++) begin
      line = rnd_line(); exp_q.push_back(line); push(line);
    end
    wait_done("t1", 50, d0);
    verify("t1", 256, base);
    chk("t1_latency", obs_q[base].cyc, p + 2);
    for (int i = 1; i < 4; i++) chk("t1_consec", obs_q[base+i].cyc - obs_q[base].cyc, i);
    chk("t1_done_cyc", last_done, obs_q[base+3].cyc + 1);
    chk("t1_err", err_o, 0);

    // 100 bytes: 64 + 36
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(100);
    for (int i = 0; i < 2; i++) begin
      line = rnd_line(); exp_q.push_back(line); push(line);
    end
    wait_done("t2", 50, d0);
    verify("t2", 100, base);
    chk("t2_busy_at_done", mon_busy[last_done], 0);
    chk("t2_busy_before", mon_busy[last_done-1], 1);

    // zero length
    base = obs_q.size(); d0 = done_count;
    s = now();
    start_xfer(0);
    repeat (5) step();
    chk("t3_done_cnt", done_count - d0, 1);
    chk("t3_done_cyc", last_done, s + 1);
    chk("t3_no_beats", obs_q.size() - base, 0);
    busy_sum = 0;
    for (int c = s; c <= s + 5; c++) busy_sum += int'(mon_busy[c]);
    chk("t3_busy", busy_sum, 0);

    // 1024 bytes with a 5-cycle ready drop
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(1024);
    pushed = 0; k = 0;
    for (int c = 0; c < 400 && done_count == d0; c++) begin
      if (c == 6) begin bus.acc_data_ready_i = 1'b0; k = now(); end
      if (c == 11) bus.acc_data_ready_i = 1'b1;
      if (pushed < 16 && bus.line_ready_o) begin
        line = rnd_line(); exp_q.push_back(line);
        bus.line_val_i = 1'b1; bus.line_dat_i = line; pushed++;
      end else bus.line_val_i = 1'b0;
      step();
    end
    bus.line_val_i = 1'b0;
    step();
    chk("t4_done", done_count - d0, 1);
    verify("t4", 1024, base);
    for (int j = 3; j <= 6; j++) chk("t4_quiet", mon_val[k+j], 0);
    chk("t4_err", err_o, 0);

    // overflow with ready low: 8 stored, 2 dropped
    bus.acc_data_ready_i = 1'b0;
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(1024);
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("t5_err_before", err_o, 0);
      line = rnd_line();
      if (i < 8) exp_q.push_back(line);
      push(line);
    end
    step(); step();
    chk("t5_err", err_o, 1);
    chk("t5_no_out", obs_q.size() - base, 0);
    chk("t5_lrdy", bus.line_ready_o, 0);
    bus.acc_data_ready_i = 1'b1;
    pushed = 8;
    for (int c = 0; c < 400 && done_count == d0; c++) begin
      if (pushed < 16 && bus.line_ready_o) begin
        line = rnd_line(); exp_q.push_back(line);
        bus.line_val_i = 1'b1; bus.line_dat_i = line; pushed++;
      end else bus.line_val_i = 1'b0;
      step();
    end
    bus.line_val_i = 1'b0;
    step();
    chk("t5_done", done_count - d0, 1);
    verify("t5", 1024, base);
    chk("t5_err_sticky", err_o, 1);

    // start clears err; an extra line beyond the length sets it again
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(64);
    chk("t5b_err_clr", err_o, 0);
    line = rnd_line(); exp_q.push_back(line); push(line);
    push(rnd_line());
    step();
    chk("t5b_err", err_o, 1);
    wait_done("t5b", 50, d0);
    verify("t5b", 64, base);

    // reset after 3 of 8 beats
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(512);
    pushed = 0;
    for (int c = 0; c < 100 && obs_q.size() - base < 3; c++) begin
      if (pushed < 8 && bus.line_ready_o) begin
        bus.line_val_i = 1'b1; bus.line_dat_i = rnd_line(); pushed++;
      end else bus.line_val_i = 1'b0;
      step();
    end
    bus.line_val_i = 1'b0;
    chk("t6_three", obs_q.size() - base, 3);
    reset = 1'b1;
    #1;
    chk("t6_val",  bus.acc_data_val_o, 0);
    chk("t6_eop",  bus.acc_data_eop_o, 0);
    chk("t6_byte", bus.acc_data_byte_o, 0);
    chk("t6_dat",  bus.acc_data_dat_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_err",  err_o, 0);
    dr = done_count;
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("t6_no_done", done_count - dr, 0);
    base = obs_q.size(); d0 = done_count; exp_q.delete();
    start_xfer(64);
    line = rnd_line(); exp_q.push_back(line); push(line);
    wait_done("t6b", 50, d0);
    verify("t6b", 64, base);

    // randomized lengths, ready and line gaps
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 700);
      nl  = (len + 63) / 64;
      base = obs_q.size(); d0 = done_count; exp_q.delete();
      start_xfer(len);
      pushed = 0;
      for (int c = 0; c < 2000 && done_count == d0; c++) begin
        bus.acc_data_ready_i = ($urandom_range(0, 3) != 0);
        if (pushed < nl && bus.line_ready_o && $urandom_range(0, 1) == 1) begin
          line = rnd_line(); exp_q.push_back(line);
          bus.line_val_i = 1'b1; bus.line_dat_i = line; pushed++;
        end else bus.line_val_i = 1'b0;
        step();
      end
      bus.line_val_i = 1'b0;
      bus.acc_data_ready_i = 1'b1;
      step();
      chk("t7_done", done_count - d0, 1);
      verify("t7", len, base);
      chk("t7_err", err_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
